instruction_fetch: RTL and testbench

//  LEGv8 fetch stage, directly upstream of SignExtend. Owns the 64-bit PC and issues word

---
 rtl/fetch_pkg.sv | 15 +
 rtl/instruction_fetch_branch_target_adder.sv | 13 +
 rtl/instruction_fetch.sv | 109 ++++++++++
 tb/tb_instruction_fetch.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the LEGv8 instruction fetch stage.
package fetch_pkg;

    localparam int unsigned DEF_PC_WIDTH    = 64;
    localparam int unsigned DEF_INSTR_WIDTH = 32;
    localparam int unsigned INSTR_BYTES     = 4;
    localparam logic [63:0] DEF_RESET_PC    = 64'h0;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t FETCH = 2'd0;
    localparam fetch_state_t HOLD  = 2'd1;
    localparam fetch_state_t DRAIN = 2'd2;

endpackage

// File: rtl/instruction_fetch_branch_target_adder.sv
// Redirect target: branch PC plus the sign-extended word offset scaled to bytes.
module branch_target_adder #(
    parameter int unsigned PC_WIDTH = 64
) (
    input  logic [PC_WIDTH-1:0] base,
    input  logic [PC_WIDTH-1:0] offset,
    output logic [PC_WIDTH-1:0] target_c
);

    // Offset bits shifted past the top are dropped; the add wraps silently.
    assign target_c = base + (offset << 2);

endmodule

// File: rtl/instruction_fetch.sv
// LEGv8 fetch stage: owns the PC, reads instruction memory and hands words to decode.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned          PC_WIDTH    = DEF_PC_WIDTH,
    parameter int unsigned          INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = PC_WIDTH'(DEF_RESET_PC)
) (
    input  logic                   Clock,
    input  logic                   Reset,
    output logic                   IMemReq,
    output logic [PC_WIDTH-1:0]    IMemAddr,
    input  logic [INSTR_WIDTH-1:0] IMemData,
    input  logic                   IMemAck,
    input  logic                   BranchTaken,
    input  logic [PC_WIDTH-1:0]    BranchPC,
    input  logic [PC_WIDTH-1:0]    BranchOffset,
    output logic [INSTR_WIDTH-1:0] Instruction,
    output logic [PC_WIDTH-1:0]    InstrPC,
    output logic                   InstrValid,
    input  logic                   DecodeReady
);

    fetch_state_t           state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    drain_addr_q, drain_addr_d;
    logic [PC_WIDTH-1:0]    instr_pc_q, instr_pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic [PC_WIDTH-1:0]    target_c;

    branch_target_adder #(.PC_WIDTH(PC_WIDTH)) u_target (
        .base     (BranchPC),
        .offset   (BranchOffset),
        .target_c (target_c)
    );

    // Next-state logic; a redirect outranks every event except reset.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        valid_d      = valid_q;

        if (BranchTaken) begin
            pc_d    = {target_c[PC_WIDTH-1:2], pc_q[1:0]};
            valid_d = 1'b0;
            case (state_q)
                FETCH: begin
                    if (!IMemAck) begin
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end
                HOLD:    state_d = FETCH;
                DRAIN:   if (IMemAck) state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (IMemAck) begin
                        instr_d    = IMemData;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        pc_d       = pc_q + PC_WIDTH'(INSTR_BYTES);
                        state_d    = HOLD;
                    end
                end
                HOLD: begin
                    if (DecodeReady) begin
                        valid_d = 1'b0;
                        state_d = FETCH;
                    end
                end
                DRAIN:   if (IMemAck) state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            instr_q      <= '0;
            instr_pc_q   <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            valid_q      <= valid_d;
        end
    end

    // While draining, the abandoned request must keep its original address until acked.
    assign IMemReq     = ((state_q == FETCH) || (state_q == DRAIN)) && !Reset;
    assign IMemAddr    = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign Instruction = instr_q;
    assign InstrPC     = instr_pc_q;
    assign InstrValid  = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch with a transaction-level reference model.
module tb_instruction_fetch;

    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        Reset, IMemReq, IMemAck, BranchTaken, InstrValid, DecodeReady;
    logic [63:0] IMemAddr, BranchPC, BranchOffset, InstrPC;
    logic [31:0] IMemData, Instruction;

    logic        r2, req2, ack2, valid2, dr2;
    logic [63:0] addr2, ipc2;
    logic [31:0] data2, instr2;

    instruction_fetch u_dut (
        .Clock(Clock), .Reset(Reset), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .IMemData(IMemData), .IMemAck(IMemAck), .BranchTaken(BranchTaken),
        .BranchPC(BranchPC), .BranchOffset(BranchOffset), .Instruction(Instruction),
        .InstrPC(InstrPC), .InstrValid(InstrValid), .DecodeReady(DecodeReady)
    );

    instruction_fetch #(.RESET_PC(WRAP_PC)) u_wrap (
        .Clock(Clock), .Reset(r2), .IMemReq(req2), .IMemAddr(addr2),
        .IMemData(data2), .IMemAck(ack2), .BranchTaken(1'b0),
        .BranchPC(64'h0), .BranchOffset(64'h0), .Instruction(instr2),
        .InstrPC(ipc2), .InstrValid(valid2), .DecodeReady(dr2)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: PC, the instruction presented to decode, and any stale read in flight.
    logic [63:0] m_pc, m_ipc, m_stale_addr;
    logic [31:0] m_instr;
    logic        m_valid, m_stale;

    int          mem_cnt = -1;
    int          lat_mode = 0;
    logic [63:0] mem_addr;

    function automatic logic [31:0] memf(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic bt, input logic [63:0] bpc,
                         input logic [63:0] boff, input logic dr);
        logic        ack;
        logic [31:0] data;
        logic        exp_req;
        @(negedge Clock);
        Reset = r; BranchTaken = bt; BranchPC = bpc; BranchOffset = boff;
        DecodeReady = dr; IMemAck = 1'b0; IMemData = $urandom;
        #1;
        if (r) begin
            mem_cnt = -1;
        end else if (IMemReq) begin
            if (mem_cnt < 0) begin
                mem_cnt  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
                mem_addr = IMemAddr;
            end else begin
                check("addr_stable", IMemAddr, mem_addr);
            end
            if (mem_cnt == 0) begin
                IMemAck  = 1'b1;
                IMemData = memf(mem_addr);
                mem_cnt  = -1;
            end else begin
                mem_cnt--;
            end
        end else if (lat_mode < 0 && $urandom_range(0, 7) == 0) begin
            IMemAck = 1'b1;
        end
        #1;
        exp_req = !r && !m_valid;
        check("req", IMemReq, exp_req);
        if (exp_req) check("addr", IMemAddr, m_stale ? m_stale_addr : m_pc);
        check("valid", InstrValid, m_valid);
        check("instr", Instruction, m_instr);
        check("instr_pc", InstrPC, m_ipc);
        ack  = IMemAck;
        data = IMemData;
        @(posedge Clock);
        if (r) begin
            m_pc = 64'h0; m_valid = 1'b0; m_instr = '0; m_ipc = '0; m_stale = 1'b0;
        end else if (bt) begin
            if (m_stale) begin
                m_stale = !ack;
            end else if (!m_valid && !ack) begin
                m_stale      = 1'b1;
                m_stale_addr = m_pc;
            end
            m_valid = 1'b0;
            m_pc    = bpc + boff * 64'd4;
        end else if (m_stale) begin
            if (ack) m_stale = 1'b0;
        end else if (m_valid) begin
            if (dr) m_valid = 1'b0;
        end else if (ack) begin
            m_instr = data; m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 64'd4;
        end
        #1;
    endtask

    initial begin
        Reset = 1'b1; BranchTaken = 1'b0; BranchPC = '0; BranchOffset = '0;
        DecodeReady = 1'b0; IMemAck = 1'b0; IMemData = '0;
        r2 = 1'b1; ack2 = 1'b0; data2 = '0; dr2 = 1'b0;
        m_pc = '0; m_valid = 1'b0; m_instr = '0; m_ipc = '0; m_stale = 1'b0; m_stale_addr = '0;
        mem_addr = '0;

        // Sequential fetch with single-cycle memory
        cycle(1, 0, 0, 0, 1);
        check("rst_valid", InstrValid, 0);
        check("rst_ipc", InstrPC, 0);
        check("rst_instr", Instruction, 0);
        cycle(0, 0, 0, 0, 1);
        check("f0_ipc", InstrPC, 64'h0);
        check("f0_instr", Instruction, 64'h5A5A_1234);
        check("f0_valid", InstrValid, 1);
        cycle(0, 0, 0, 0, 1);
        check("f1_addr", IMemAddr, 64'h4);
        cycle(0, 0, 0, 0, 1);
        check("f1_ipc", InstrPC, 64'h4);

        // Decode stall in HOLD
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, 0);
            check("stall_ipc", InstrPC, 64'h4);
            check("stall_req", IMemReq, 0);
        end
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        check("f2_ipc", InstrPC, 64'h8);

        // Redirect from HOLD with negative offset
        cycle(0, 1, 64'h40, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        check("hold_br_valid", InstrValid, 0);
        check("hold_br_addr", IMemAddr, 64'h30);

        // Redirect during a slow read drains the stale request
        lat_mode = 3;
        cycle(0, 1, 64'h100, 64'h10, 1);
        check("drain_addr", IMemAddr, 64'h30);
        check("drain_req", IMemReq, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        check("drain_hold_addr", IMemAddr, 64'h30);
        check("drain_valid", InstrValid, 0);
        cycle(0, 0, 0, 0, 1);
        check("post_drain_addr", IMemAddr, 64'h140);
        check("post_drain_valid", InstrValid, 0);

        // Redirect coincident with ack drops the data
        lat_mode = 0;
        cycle(0, 1, 64'h200, 64'h2, 1);
        check("coinc_valid", InstrValid, 0);
        check("coinc_addr", IMemAddr, 64'h208);
        cycle(0, 0, 0, 0, 1);
        check("coinc_ipc", InstrPC, 64'h208);
        check("coinc_instr", Instruction, 64'(memf(64'h208)));
        cycle(0, 0, 0, 0, 1);

        // Reset while draining abandons the read
        lat_mode = 3;
        cycle(0, 1, 64'h80, 64'h0, 1);
        check("rd_addr", IMemAddr, 64'h20C);
        cycle(1, 0, 0, 0, 1);
        check("rd_req", IMemReq, 0);
        check("rd_valid", InstrValid, 0);
        lat_mode = 0;
        cycle(0, 0, 0, 0, 1);
        check("rd_ipc", InstrPC, 64'h0);
        check("rd_val", InstrValid, 1);

        // Randomized traffic
        lat_mode = -1;
        for (int n = 0; n < 4000; n++) begin
            logic [63:0] bpc, boff;
            int          s;
            bpc = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 1) == 1) begin
                boff = {$urandom, $urandom};
            end else begin
                s    = int'($urandom_range(0, 127)) - 64;
                boff = 64'(s);
            end
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, bpc, boff,
                  $urandom_range(0, 2) != 0);
        end

        // PC wrap from a top-of-memory reset vector
        @(negedge Clock);
        r2 = 1'b0;
        #1;
        check("wrap_req", req2, 1);
        check("wrap_addr", addr2, WRAP_PC);
        ack2 = 1'b1;
        data2 = 32'hDEAD_BEEF;
        @(posedge Clock);
        #1;
        ack2 = 1'b0;
        check("wrap_ipc", ipc2, WRAP_PC);
        check("wrap_instr", instr2, 64'hDEAD_BEEF);
        check("wrap_valid", valid2, 1);
        @(negedge Clock);
        dr2 = 1'b1;
        @(posedge Clock);
        #1;
        check("wrap_next_addr", addr2, 64'h0);
        check("wrap_next_req", req2, 1);
        check("wrap_next_valid", valid2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
